// File: rtl/jpeg_pixel_packer.sv
// jpeg_pixel_packer: serialises decoded pixels into a little-endian byte
// stream and packs it into 32-bit words with a byte strobe and frame-last flag.
// Optional build macro: JPEG_PIXEL_PACK_RGB565_EN selects 2-byte RGB565 pixels
// instead of the default 3-byte RGB888 (R, G, B order).
// Handshake: a transfer happens on a rising edge where valid and accept are
// both high; a presented word holds data/strb/last until it is accepted.
module jpeg_pixel_packer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        pixel_valid_i,
   input  logic [15:0] pixel_width_i,
   input  logic [15:0] pixel_height_i,
   input  logic [15:0] pixel_x_i,
   input  logic [15:0] pixel_y_i,
   input  logic [7:0]  pixel_r_i,
   input  logic [7:0]  pixel_g_i,
   input  logic [7:0]  pixel_b_i,
   output logic        pixel_accept_o,
   output logic        outport_valid_o,
   output logic [31:0] outport_data_o,
   output logic [3:0]  outport_strb_o,
   output logic        outport_last_o,
   input  logic        outport_accept_i,
   output logic        frame_done_o,
   output logic        idle_o
);

`ifdef JPEG_PIXEL_PACK_RGB565_EN
   localparam logic [2:0] BPP = 3'd2;
`else
   localparam logic [2:0] BPP = 3'd3;
`endif

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;        // residual byte count
   logic [23:0] res_q, res_d;        // residual bytes, byte 0 in [7:0], zero above cnt
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic [3:0]  out_strb_q, out_strb_d;
   logic        out_last_q, out_last_d;
   logic        frame_done_q, frame_done_d;

   logic [23:0] pix_bytes;
   logic [55:0] cat;                 // residual bytes followed by the new pixel's bytes
   logic [2:0]  total;
   logic        out_free;
   logic        pixel_fire;
   logic        is_last;

   function automatic logic [3:0] strb_mask(input logic [2:0] n);
      case (n)
         3'd0:    strb_mask = 4'b0000;
         3'd1:    strb_mask = 4'b0001;
         3'd2:    strb_mask = 4'b0011;
         3'd3:    strb_mask = 4'b0111;
         default: strb_mask = 4'b1111;
      endcase
   endfunction

   // Format the incoming pixel as a little-endian byte group (unused bytes zero)
`ifdef JPEG_PIXEL_PACK_RGB565_EN
   logic [15:0] p565;
   logic        unused_pix_bits;
   assign unused_pix_bits = ^{pixel_r_i[2:0], pixel_g_i[1:0], pixel_b_i[2:0]};
   always_comb begin
      p565      = {pixel_r_i[7:3], pixel_g_i[7:2], pixel_b_i[7:3]};
      pix_bytes = {8'h00, p565};
   end
`else
   always_comb begin
      pix_bytes = {pixel_b_i, pixel_g_i, pixel_r_i};
   end
`endif

   // Next-state logic: byte accumulation, word loading and RUN/FLUSH control
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      res_d        = res_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_strb_d   = out_strb_q;
      out_last_d   = out_last_q;

      out_free     = !out_valid_q || outport_accept_i;
      pixel_fire   = pixel_valid_i && (state_q == ST_RUN) && out_free;
      is_last      = (pixel_x_i == pixel_width_i - 16'd1) &&
                     (pixel_y_i == pixel_height_i - 16'd1);
      total        = {1'b0, cnt_q} + BPP;
      cat          = ({32'h0, pix_bytes} << {cnt_q, 3'b000}) | {32'h0, res_q};
      frame_done_d = out_valid_q && outport_accept_i && out_last_q;

      if (out_valid_q && outport_accept_i) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_RUN: begin
            if (pixel_fire) begin
               if (total >= 3'd4) begin
                  // total is 4..6, so its low two bits are the leftover count
                  out_valid_d = 1'b1;
                  out_data_d  = cat[31:0];
                  out_strb_d  = 4'hF;
                  out_last_d  = is_last && (total == 3'd4);
                  res_d       = cat[55:32];
                  cnt_d       = total[1:0];
                  if (is_last && (total > 3'd4)) begin
                     state_d = ST_FLUSH;
                  end
               end else if (is_last) begin
                  out_valid_d = 1'b1;
                  out_data_d  = cat[31:0];
                  out_strb_d  = strb_mask(total);
                  out_last_d  = 1'b1;
                  res_d       = 24'h0;
                  cnt_d       = 2'd0;
               end else begin
                  res_d = cat[23:0];
                  cnt_d = total[1:0];
               end
            end
         end
         default: begin
            // FLUSH: leftover bytes of the final pixel become the last word
            if (out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = {8'h00, res_q};
               out_strb_d  = strb_mask({1'b0, cnt_q});
               out_last_d  = 1'b1;
               res_d       = 24'h0;
               cnt_d       = 2'd0;
               state_d     = ST_RUN;
            end
         end
      endcase
   end

   // State registers with synchronous reset; a reset drops any partial frame
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_RUN;
         cnt_q        <= 2'd0;
         res_q        <= 24'h0;
         out_valid_q  <= 1'b0;
         out_data_q   <= 32'h0;
         out_strb_q   <= 4'h0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         res_q        <= res_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_strb_q   <= out_strb_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign pixel_accept_o  = (state_q == ST_RUN) && (!out_valid_q || outport_accept_i);
   assign outport_valid_o = out_valid_q;
   assign outport_data_o  = out_data_q;
   assign outport_strb_o  = out_strb_q;
   assign outport_last_o  = out_last_q;
   assign frame_done_o    = frame_done_q;
   assign idle_o          = (state_q == ST_RUN) && (cnt_q == 2'd0) && !out_valid_q;

endmodule

// File: tb/tb_jpeg_pixel_packer.sv
// Bench for jpeg_pixel_packer: directed frames plus random frames whose
// expected words come from a byte-stream model (concatenate all pixel bytes,
// cut into 4-byte words, last word partial). Honours JPEG_PIXEL_PACK_RGB565_EN.
module tb_jpeg_pixel_packer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        pixel_valid_i = 1'b0;
   logic [15:0] pixel_width_i = 16'd1;
   logic [15:0] pixel_height_i = 16'd1;
   logic [15:0] pixel_x_i = 16'd0;
   logic [15:0] pixel_y_i = 16'd0;
   logic [7:0]  pixel_r_i = 8'h0;
   logic [7:0]  pixel_g_i = 8'h0;
   logic [7:0]  pixel_b_i = 8'h0;
   logic        pixel_accept_o;
   logic        outport_valid_o;
   logic [31:0] outport_data_o;
   logic [3:0]  outport_strb_o;
   logic        outport_last_o;
   logic        outport_accept_i = 1'b0;
   logic        frame_done_o;
   logic        idle_o;

   jpeg_pixel_packer dut (
      .clk_i(clk_i), .rst_i(rst_i), .pixel_valid_i(pixel_valid_i),
      .pixel_width_i(pixel_width_i), .pixel_height_i(pixel_height_i),
      .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i),
      .pixel_r_i(pixel_r_i), .pixel_g_i(pixel_g_i), .pixel_b_i(pixel_b_i),
      .pixel_accept_o(pixel_accept_o), .outport_valid_o(outport_valid_o),
      .outport_data_o(outport_data_o), .outport_strb_o(outport_strb_o),
      .outport_last_o(outport_last_o), .outport_accept_i(outport_accept_i),
      .frame_done_o(frame_done_o), .idle_o(idle_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int acc_mode = 1;          // 0 random, 1 always accept, 2 never accept
   bit in_reset = 1'b1;
   bit done_exp = 1'b0;

   // expected words: {last, strb[3:0], data[31:0]}
   logic [36:0] exp_q[$];
   logic [7:0]  pr[$], pg[$], pb[$];

   task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // Downstream accept pattern, changed just after each rising edge
   always @(posedge clk_i) begin
      #1;
      case (acc_mode)
         0:       outport_accept_i = 1'($urandom_range(0, 1));
         1:       outport_accept_i = 1'b1;
         default: outport_accept_i = 1'b0;
      endcase
   end

   // ---------------- scoreboard (samples on falling edge) ----------------
   always @(negedge clk_i) begin
      if (in_reset) begin
         done_exp = 1'b0;
      end else begin
         check("frame_done", 37'(frame_done_o), 37'(done_exp));
         done_exp = 1'b0;
         if (outport_valid_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", {outport_last_o, outport_strb_o, outport_data_o}, 37'h0);
            end else begin
               check("word_data", 37'(outport_data_o), 37'(exp_q[0][31:0]));
               check("word_strb", 37'(outport_strb_o), 37'(exp_q[0][35:32]));
               check("word_last", 37'(outport_last_o), 37'(exp_q[0][36]));
               if (outport_accept_i) begin
                  if (exp_q[0][36]) done_exp = 1'b1;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // Frame pixels in pr/pg/pb (raster order) -> expected words in exp_q
   task automatic model_frame();
      logic [7:0]  bytes[$];
      logic [15:0] p;
      logic [31:0] d;
      logic [3:0]  s;
      for (int i = 0; i < pr.size(); i++) begin
`ifdef JPEG_PIXEL_PACK_RGB565_EN
         p = {pr[i][7:3], pg[i][7:2], pb[i][7:3]};
         bytes.push_back(p[7:0]);
         bytes.push_back(p[15:8]);
`else
         bytes.push_back(pr[i]);
         bytes.push_back(pg[i]);
         bytes.push_back(pb[i]);
`endif
      end
      for (int k = 0; k < bytes.size(); k += 4) begin
         d = 32'h0;
         s = 4'h0;
         for (int j = 0; j < 4; j++) begin
            if (k + j < bytes.size()) begin
               d[8*j +: 8] = bytes[k + j];
               s[j] = 1'b1;
            end
         end
         exp_q.push_back({(k + 4 >= bytes.size()), s, d});
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive_pixel(input int w, input int h, input int x, input int y,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      bit got = 1'b0;
      int cyc = 0;
      pixel_valid_i  = 1'b1;
      pixel_width_i  = 16'(w);
      pixel_height_i = 16'(h);
      pixel_x_i      = 16'(x);
      pixel_y_i      = 16'(y);
      pixel_r_i      = r;
      pixel_g_i      = g;
      pixel_b_i      = b;
      while (!got && cyc < 500) begin
         @(negedge clk_i);
         got = pixel_accept_o;
         @(posedge clk_i);
         #1;
         cyc++;
      end
      if (!got) check("pixel_accept_timeout", 37'(got), 37'(1));
      pixel_valid_i = 1'b0;
   endtask

   task automatic send_frame(input int w, input int h, input bit gaps);
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            drive_pixel(w, h, x, y, pr[y*w+x], pg[y*w+x], pb[y*w+x]);
            if (gaps && $urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) @(posedge clk_i);
               #1;
            end
         end
      end
   endtask

   task automatic wait_drain(input string tag);
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < 1000) begin
         @(posedge clk_i);
         cyc++;
      end
      check({tag, "_drain"}, 37'(exp_q.size()), 37'(0));
      exp_q.delete();
      @(posedge clk_i);
      @(negedge clk_i);
      check({tag, "_idle"}, 37'(idle_o), 37'(1));
      check({tag, "_valid_low"}, 37'(outport_valid_o), 37'(0));
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_pix(input logic [23:0] rgb);
      pr.push_back(rgb[23:16]);
      pg.push_back(rgb[15:8]);
      pb.push_back(rgb[7:0]);
   endtask

   task automatic clear_pix();
      pr.delete();
      pg.delete();
      pb.delete();
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      in_reset = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      check("rst_valid", 37'(outport_valid_o), 37'(0));
      check("rst_data", 37'(outport_data_o), 37'(0));
      check("rst_strb", 37'(outport_strb_o), 37'(0));
      check("rst_last", 37'(outport_last_o), 37'(0));
      check("rst_frame_done", 37'(frame_done_o), 37'(0));
      check("rst_idle", 37'(idle_o), 37'(1));
      check("rst_pixel_accept", 37'(pixel_accept_o), 37'(1));
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      exp_q.delete();
      in_reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w, h, cyc;
      do_reset();

`ifdef JPEG_PIXEL_PACK_RGB565_EN
      // 2x1 RGB565 frame
      clear_pix();
      set_pix(24'hFF00FF);
      set_pix(24'h00FF00);
      exp_q.push_back({1'b1, 4'hF, 32'h07E0F81F});
      send_frame(2, 1, 1'b0);
      wait_drain("rgb565_2x1");
`else
      // 2x2 frame
      clear_pix();
      set_pix(24'h112233); set_pix(24'h445566); set_pix(24'h778899); set_pix(24'hAABBCC);
      exp_q.push_back({1'b0, 4'hF, 32'h44332211});
      exp_q.push_back({1'b0, 4'hF, 32'h88776655});
      exp_q.push_back({1'b1, 4'hF, 32'hCCBBAA99});
      send_frame(2, 2, 1'b0);
      wait_drain("frame_2x2");

      // 1x1 frame
      clear_pix();
      set_pix(24'h010203);
      exp_q.push_back({1'b1, 4'b0111, 32'h00030201});
      send_frame(1, 1, 1'b0);
      wait_drain("frame_1x1");

      // 3x1 frame ending through FLUSH
      clear_pix();
      set_pix(24'h010203); set_pix(24'h040506); set_pix(24'h070809);
      exp_q.push_back({1'b0, 4'hF, 32'h04030201});
      exp_q.push_back({1'b0, 4'hF, 32'h08070605});
      exp_q.push_back({1'b1, 4'b0001, 32'h00000009});
      send_frame(3, 1, 1'b0);
      wait_drain("frame_3x1_flush");
`endif

      // Backpressure: downstream stalls for 10 cycles with a word pending
      clear_pix();
      for (int i = 0; i < 4; i++) set_pix(24'($urandom));
      model_frame();
      acc_mode = 2;
      fork
         send_frame(2, 2, 1'b0);
         begin
            cyc = 0;
            while (!outport_valid_o && cyc < 50) begin
               @(negedge clk_i);
               cyc++;
            end
            check("bp_word_seen", 37'(outport_valid_o), 37'(1));
            repeat (10) begin
               @(negedge clk_i);
               check("bp_pixel_accept", 37'(pixel_accept_o), 37'(0));
               check("bp_valid_held", 37'(outport_valid_o), 37'(1));
            end
            @(posedge clk_i);
            #1;
            acc_mode = 1;
         end
      join
      wait_drain("backpressure");

      // Random frames with random accept pattern and input gaps
      for (int f = 0; f < 10; f++) begin
         w = $urandom_range(1, 5);
         h = $urandom_range(1, 3);
         clear_pix();
         for (int i = 0; i < w*h; i++) set_pix(24'($urandom));
         model_frame();
         acc_mode = (f % 3 == 2) ? 1 : 0;
         send_frame(w, h, 1'b1);
         acc_mode = 0;
         wait_drain("random_frame");
      end
      acc_mode = 1;

      // Reset after the first pixel of a 2x2 frame, then a fresh 1x1 frame
      drive_pixel(2, 2, 0, 0, 8'h5A, 8'hA5, 8'h3C);
      do_reset();
      clear_pix();
      set_pix(24'h0A0B0C);
      model_frame();
      check("post_reset_words", 37'(exp_q.size()), 37'(1));
      send_frame(1, 1, 1'b0);
      wait_drain("post_reset_1x1");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jpeg_pixel_packer.md
JPEG_PIXEL_PACKER -- requirements
Module: jpeg_pixel_packer

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port pixel_valid_i, input, 1 bit: pixel presented by the decoder outport.
REQ-004 SHALL have ports pixel_width_i and pixel_height_i, input, 16 bits each: image dimensions.
REQ-005 SHALL have ports pixel_x_i and pixel_y_i, input, 16 bits each: pixel coordinates.
REQ-006 SHALL have ports pixel_r_i, pixel_g_i and pixel_b_i, input, 8 bits each: pixel colour.
REQ-007 SHALL have port pixel_accept_o, output, 1 bit: pixel consumed this cycle when high together with pixel_valid_i.
REQ-008 SHALL have port outport_valid_o, output, 1 bit: packed word valid.
REQ-009 SHALL have port outport_data_o, output, 32 bits: packed bytes, byte 0 in [7:0].
REQ-010 SHALL have port outport_strb_o, output, 4 bits: valid-byte mask, contiguous from bit 0.
REQ-011 SHALL have port outport_last_o, output, 1 bit: final word of the frame.
REQ-012 SHALL have port outport_accept_i, input, 1 bit: downstream takes the word when high together with outport_valid_o.
REQ-013 SHALL have port frame_done_o, output, 1 bit: one-cycle pulse after the last word is accepted.
REQ-014 SHALL have port idle_o, output, 1 bit: high when in RUN with no residual bytes and outport_valid_o low.

Function
REQ-015 SHALL serialise each pixel as bytes R, G, B, in that order, into a little-endian byte stream.
REQ-016 SHALL hold a residual byte count r (0..3) plus one registered output word.
REQ-017 SHALL implement state machine RUN/FLUSH.
REQ-018 SHALL drive pixel_accept_o = (state==RUN) && (!outport_valid_o || outport_accept_i); this combinational path from outport_accept_i is permitted.
REQ-019 SHALL, on pixel accept, append the pixel's bytes at residual position r, giving total t = r + bytes_per_pixel.
REQ-020 SHALL, when t>=4, load bytes 0..3 into the output word with strb 4'hF; residual becomes t-4.
REQ-021 SHALL flag the frame's last pixel as pixel_x_i==pixel_width_i-1 and pixel_y_i==pixel_height_i-1.
REQ-022 SHALL, for the last pixel with t<4, emit all t bytes immediately with strb = (1<<t)-1, last=1 and r=0.
REQ-023 SHALL, for the last pixel with t==4, set last=1 on that word.
REQ-024 SHALL, for the last pixel with t>4, emit a full word with last=0 and enter FLUSH.
REQ-025 SHALL, in FLUSH, when the output register is free, emit the residual bytes with a partial strb and last=1, then return to RUN with r=0.
REQ-026 SHALL zero unused data bytes of a partial word.
REQ-027 SHALL present a word on outport_valid_o the cycle after the completing pixel accept, or the FLUSH transition.
REQ-028 SHALL hold outport_data_o, outport_strb_o and outport_last_o stable while outport_valid_o is high and outport_accept_i is low.
REQ-029 SHALL support back-to-back operation: a word accepted and a new word loaded in the same cycle gives no bubble.
REQ-030 SHALL not check coordinate ordering; the last-pixel flag alone terminates the frame.

Reset
REQ-031 SHALL, on rst_i, set state=RUN, r=0, outport_valid_o=0, outport_data_o=0, outport_strb_o=0, outport_last_o=0, frame_done_o=0; pixel_accept_o follows REQ-018 (high); idle_o=1.
REQ-032 SHALL, on reset mid-frame, discard residual bytes and any pending word with no last emitted.

Configuration
REQ-033 SHALL, with JPEG_PIXEL_PACK_RGB565_EN defined, pack each pixel as 2 bytes {r[7:3],g[7:2],b[7:3]} (low byte first), giving bytes_per_pixel=2, r in {0,2}, and FLUSH unreachable.
REQ-034 SHALL, without JPEG_PIXEL_PACK_RGB565_EN, pack each pixel as RGB888 with bytes_per_pixel=3.

Verification
REQ-035 SHALL verify a 2x2 RGB888 frame with pixels 112233, 445566, 778899, AABBCC -> words 0x44332211, 0x88776655, 0xCCBBAA99, strb F, last on the third word, then a frame_done_o pulse.
REQ-036 SHALL verify a 1x1 frame with pixel (01,02,03) -> a single word 0x00030201, strb 0111, last=1.
REQ-037 SHALL verify a 3x1 frame with pixels 010203, 040506, 070809 -> 0x04030201, 0x08070605, then FLUSH word 0x00000009, strb 0001, last=1.
REQ-038 SHALL verify backpressure: outport_accept_i held low 10 cycles -> pixel_accept_o low, word stable, no word lost or duplicated after release.
REQ-039 SHALL verify, with the RGB565 macro, a 2x1 frame with pixels (FF,00,FF), (00,FF,00) -> word 0x07E0F81F, strb F, last=1.
REQ-040 SHALL verify rst_i asserted after 1 pixel of a 2x2 frame -> outputs at reset values next cycle, and a new 1x1 frame emits exactly one word.
